// File: rtl/pf_scroll_pkg.sv
// Shared constants, types and the wrap-around helper for the multi-layer
// vertical playfield scroll block.
package pf_scroll_pkg;

  // Bit positions inside the scroll and attribute data words.
  localparam int VBD_IMM_BIT   = 15;
  localparam int VRD_HFLIP_BIT = 15;
  localparam int VRD_BANK_BIT  = 14;

  // {bank, picture page[5:0]}
  localparam int PP_WIDTH = 7;

  // One layer's attribute payload as captured on an HDL falling edge.
  typedef struct packed {
    logic                hflip;
    logic [PP_WIDTH-1:0] pp;
  } attr_t;

  // Modular add for operands already below height; one subtraction is enough.
  function automatic int unsigned wrap_add(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned height);
    int unsigned sum;
    sum = a + b;
    return (sum >= height) ? (sum - height) : sum;
  endfunction

endpackage

// File: rtl/pf_vscroll_lane.sv
// One playfield layer: shadow/base scroll registers, pending flag, running
// row counter and the latched attribute bits.
module pf_vscroll_lane
  import pf_scroll_pkg::*;
#(
  parameter int unsigned Y_WIDTH      = 9,
  parameter int unsigned PF_HEIGHT    = 512,
  parameter int unsigned START_OFFSET = 0
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               wr_en,
  input  logic               wr_imm,
  input  logic [Y_WIDTH-1:0] wr_val,
  input  logic               vb_rise,
  input  logic               hs_adv,
  input  logic               attr_en,
  input  attr_t              attr_in,
  output logic [Y_WIDTH-1:0] row,
  output logic               hflip,
  output logic [PP_WIDTH-1:0] pp,
  output logic               pend
);

  logic [Y_WIDTH-1:0] base;
  logic [Y_WIDTH-1:0] shadow;
  logic [Y_WIDTH-1:0] wr_folded;
  logic [Y_WIDTH-1:0] reload_base;
  logic [Y_WIDTH-1:0] reload_row;
  logic [Y_WIDTH-1:0] next_row;
  logic               wr_def;

  // Fold the written value into range and work out the reload / advance rows.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    wr_folded   = wr_val;
    reload_base = base;
    if (32'(wr_val) >= PF_HEIGHT) wr_folded = Y_WIDTH'(32'(wr_val) - PF_HEIGHT);
    wr_def = wr_en & ~wr_imm;
    // A deferred write landing on the vblank edge is taken as the new shadow.
    if (wr_def)    reload_base = wr_folded;
    else if (pend) reload_base = shadow;
    reload_row = Y_WIDTH'(wrap_add(32'(reload_base), START_OFFSET, PF_HEIGHT));
    next_row   = Y_WIDTH'(wrap_add(32'(row), 1, PF_HEIGHT));
  end

  // Scroll state: immediate write beats vblank reload beats scanline advance.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
      base   <= '0;
      shadow <= '0;
      pend   <= 1'b0;
      row    <= '0;
    end else if (wr_en && wr_imm) begin
      base <= wr_folded;
      row  <= wr_folded;
      pend <= 1'b0;
    end else if (vb_rise) begin
      base   <= reload_base;
      shadow <= reload_base;
      pend   <= 1'b0;
      row    <= reload_row;
    end else begin
      if (wr_def) begin
        shadow <= wr_folded;
        pend   <= 1'b1;
      end
      if (hs_adv) row <= next_row;
    end
  end

  // Attribute latch, loaded only when this layer is selected on an HDL fall.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      hflip <= 1'b0;
      pp    <= '0;
    end else if (attr_en) begin
      hflip <= attr_in.hflip;
      pp    <= attr_in.pp;
    end
  end

endmodule

// File: rtl/pf_vscroll_multi.sv
// Multi-layer vertical playfield scroll counter: edge detection and layer
// select decode in front of NUM_LAYERS independent scroll lanes.
module pf_vscroll_multi
  import pf_scroll_pkg::*;
#(
  parameter int NUM_LAYERS   = 2,
  parameter int Y_WIDTH      = 9,
  parameter int PF_HEIGHT    = 512,
  parameter int START_OFFSET = 0,
  localparam int SEL_W       = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1
) (
  input  logic                           clk,
  input  logic                           clr,
  input  logic                           VBLANK,
  input  logic                           HSYNC,
  input  logic                           HDL,
  input  logic                           VSCRL_WR,
  input  logic [SEL_W-1:0]               VSCRL_SEL,
  input  logic [15:0]                    VBD,
  input  logic [15:0]                    VRD,
  output logic [NUM_LAYERS*Y_WIDTH-1:0]  PF_ROW,
  output logic [NUM_LAYERS-1:0]          PFHFLIP,
  output logic [NUM_LAYERS*PP_WIDTH-1:0] PP,
  output logic [NUM_LAYERS-1:0]          VSCRL_PEND
);

  logic             hsync_q;
  logic             vblank_q;
  logic             hdl_q;
  logic             hs_rise_q;
  logic             vb_rise_q;
  logic             hdl_fall_q;
  attr_t            attr_q;
  logic [SEL_W-1:0] attr_sel_q;
  logic             hs_adv;

  // Only the low Y_WIDTH bits and the immediate flag of VBD carry meaning.
  logic unused_bits;
  assign unused_bits = ^{VBD[14:Y_WIDTH], VRD[13:6]};

  // Edge detect. The pulses are registered so an input edge reaches PF_ROW
  // two clocks later; the attribute word and select are registered with the
  // HDL pulse so the values present at the falling edge are the ones latched.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      hsync_q    <= 1'b0;
      vblank_q   <= 1'b0;
      hdl_q      <= 1'b0;
      hs_rise_q  <= 1'b0;
      vb_rise_q  <= 1'b0;
      hdl_fall_q <= 1'b0;
      attr_q     <= '0;
      attr_sel_q <= '0;
    end else begin
      hsync_q    <= HSYNC;
      vblank_q   <= VBLANK;
      hdl_q      <= HDL;
      hs_rise_q  <= HSYNC & ~hsync_q;
      vb_rise_q  <= VBLANK & ~vblank_q;
      hdl_fall_q <= ~HDL & hdl_q;
      attr_q     <= '{hflip: VRD[VRD_HFLIP_BIT], pp: {VRD[VRD_BANK_BIT], VRD[5:0]}};
      attr_sel_q <= VSCRL_SEL;
    end
  end

  // vblank_q is aligned with hs_rise_q, so it tells whether the edge fell in blank.
  assign hs_adv = hs_rise_q & ~vblank_q;

  // An out-of-range select matches no lane index, so that write or latch is dropped.
  for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_lane
    logic wr_hit;
    logic attr_hit;
    assign wr_hit   = VSCRL_WR   & (VSCRL_SEL  == SEL_W'(k));
    assign attr_hit = hdl_fall_q & (attr_sel_q == SEL_W'(k));

    pf_vscroll_lane #(
      .Y_WIDTH      (Y_WIDTH),
      .PF_HEIGHT    (PF_HEIGHT),
      .START_OFFSET (START_OFFSET)
    ) u_lane (
      .clk     (clk),
      .clr     (clr),
      .wr_en   (wr_hit),
      .wr_imm  (VBD[VBD_IMM_BIT]),
      .wr_val  (VBD[Y_WIDTH-1:0]),
      .vb_rise (vb_rise_q),
      .hs_adv  (hs_adv),
      .attr_en (attr_hit),
      .attr_in (attr_q),
      .row     (PF_ROW[k*Y_WIDTH +: Y_WIDTH]),
      .hflip   (PFHFLIP[k]),
      .pp      (PP[k*PP_WIDTH +: PP_WIDTH]),
      .pend    (VSCRL_PEND[k])
    );
  end

endmodule

// File: tb/tb_pf_vscroll_multi.sv
// Directed bench for pf_vscroll_multi: a default instance (2 layers, 9-bit,
// height 512) and a second one (3 layers, 8-bit, height 240, offset 10).
module tb_pf_vscroll_multi;

  logic clk = 1'b0;
  logic clr = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance a: defaults.
  logic        a_vblank = 0, a_hsync = 0, a_hdl = 0, a_wr = 0;
  logic        a_sel = 0;
  logic [15:0] a_vbd = '0, a_vrd = '0;
  logic [17:0] a_row;
  logic [1:0]  a_hflip, a_pend;
  logic [13:0] a_pp;

  pf_vscroll_multi u_dut_a (
    .clk(clk), .clr(clr), .VBLANK(a_vblank), .HSYNC(a_hsync), .HDL(a_hdl),
    .VSCRL_WR(a_wr), .VSCRL_SEL(a_sel), .VBD(a_vbd), .VRD(a_vrd),
    .PF_ROW(a_row), .PFHFLIP(a_hflip), .PP(a_pp), .VSCRL_PEND(a_pend)
  );

  // Instance b: short playfield with a reload offset and three layers.
  logic        b_vblank = 0, b_hsync = 0, b_hdl = 0, b_wr = 0;
  logic [1:0]  b_sel = '0;
  logic [15:0] b_vbd = '0, b_vrd = '0;
  logic [23:0] b_row;
  logic [2:0]  b_hflip, b_pend;
  logic [20:0] b_pp;

  pf_vscroll_multi #(
    .NUM_LAYERS(3), .Y_WIDTH(8), .PF_HEIGHT(240), .START_OFFSET(10)
  ) u_dut_b (
    .clk(clk), .clr(clr), .VBLANK(b_vblank), .HSYNC(b_hsync), .HDL(b_hdl),
    .VSCRL_WR(b_wr), .VSCRL_SEL(b_sel), .VBD(b_vbd), .VRD(b_vrd),
    .PF_ROW(b_row), .PFHFLIP(b_hflip), .PP(b_pp), .VSCRL_PEND(b_pend)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic a_write(input logic sel, input logic imm, input logic [14:0] val);
    a_sel = sel; a_vbd = {imm, val}; a_wr = 1'b1;
    tick();
    a_wr = 1'b0;
  endtask

  task automatic b_write(input logic [1:0] sel, input logic imm, input logic [14:0] val);
    b_sel = sel; b_vbd = {imm, val}; b_wr = 1'b1;
    tick();
    b_wr = 1'b0;
  endtask

  task automatic a_hs_pulses(input int n);
    for (int i = 0; i < n; i++) begin
      a_hsync = 1'b1; tick();
      a_hsync = 1'b0; tick();
    end
  endtask

  task automatic b_hs_pulse();
    b_hsync = 1'b1; tick();
    b_hsync = 1'b0; tick();
  endtask

  initial begin
    // Reset state.
    repeat (3) tick();
    check("rst_row_a",   32'(a_row),   32'h0);
    check("rst_pend_a",  32'(a_pend),  32'h0);
    check("rst_hflip_a", 32'(a_hflip), 32'h0);
    check("rst_pp_a",    32'(a_pp),    32'h0);
    check("rst_row_b",   32'(b_row),   32'h0);
    clr = 1'b1;
    tick();

    // Deferred write waits for vblank.
    a_write(1'b0, 1'b0, 15'h010);
    check("def_pend", 32'(a_pend), 32'h1);
    check("def_row0", 32'(a_row[0 +: 9]), 32'h0);
    a_vblank = 1'b1; tick(); tick();
    check("vb_row0", 32'(a_row[0 +: 9]), 32'h010);
    check("vb_pend", 32'(a_pend), 32'h0);
    a_vblank = 1'b0; tick();

    // Five scanlines.
    a_hs_pulses(5);
    check("hs5_row0", 32'(a_row[0 +: 9]), 32'h015);
    check("hs5_row1", 32'(a_row[9 +: 9]), 32'h005);

    // Scanlines inside vblank are ignored after the reload.
    a_vblank = 1'b1; tick(); tick();
    a_hs_pulses(2);
    check("hs_in_vb_row0", 32'(a_row[0 +: 9]), 32'h010);
    a_vblank = 1'b0; tick();

    // Deferred write to layer 1 in the same cycle as the vblank reload.
    a_hs_pulses(2);
    a_vblank = 1'b1; tick();
    a_sel = 1'b1; a_vbd = 16'h0077; a_wr = 1'b1;
    tick();
    a_wr = 1'b0;
    check("same_vb_row1", 32'(a_row[9 +: 9]), 32'h077);
    check("same_vb_row0", 32'(a_row[0 +: 9]), 32'h010);
    check("same_vb_pend", 32'(a_pend), 32'h0);
    a_vblank = 1'b0; tick();

    // Immediate write wins over a scanline in the same cycle; layer 1 advances.
    a_hsync = 1'b1; tick();
    a_hsync = 1'b0;
    a_write(1'b0, 1'b1, 15'h0AB);
    check("imm_hs_row0", 32'(a_row[0 +: 9]), 32'h0AB);
    check("imm_hs_row1", 32'(a_row[9 +: 9]), 32'h078);

    // Immediate write discards a pending deferred value.
    a_write(1'b1, 1'b0, 15'h100);
    check("pend_set1", 32'(a_pend), 32'h2);
    a_write(1'b1, 1'b1, 15'h050);
    check("imm_clr_pend", 32'(a_pend), 32'h0);
    a_vblank = 1'b1; tick(); tick();
    check("reload_row0", 32'(a_row[0 +: 9]), 32'h0AB);
    check("reload_row1", 32'(a_row[9 +: 9]), 32'h050);
    a_vblank = 1'b0; tick();

    // Attribute latch on layer 1.
    a_sel = 1'b1; a_vrd = 16'hC02A; a_hdl = 1'b1; tick();
    a_hdl = 1'b0; tick(); tick();
    a_vrd = 16'h0000;
    check("attr_hflip", 32'(a_hflip), 32'h2);
    check("attr_pp1", 32'(a_pp[7 +: 7]), 32'h6A);
    check("attr_pp0", 32'(a_pp[0 +: 7]), 32'h00);

    // Asynchronous reset mid-frame, no clock edge needed.
    a_write(1'b0, 1'b1, 15'h123);
    check("pre_clr_row0", 32'(a_row[0 +: 9]), 32'h123);
    #2 clr = 1'b0;
    #1;
    check("clr_row",   32'(a_row),   32'h0);
    check("clr_hflip", 32'(a_hflip), 32'h0);
    check("clr_pp",    32'(a_pp),    32'h0);
    check("clr_pend",  32'(a_pend),  32'h0);
    tick();
    clr = 1'b1;
    tick();
    a_hs_pulses(1);
    a_vblank = 1'b1; tick(); tick();
    check("post_clr_reload", 32'(a_row), 32'h0);
    a_vblank = 1'b0; tick();

    // Instance b: wrap at height 240.
    b_write(2'd0, 1'b1, 15'd238);
    check("b_imm_238", 32'(b_row[0 +: 8]), 32'd238);
    b_hs_pulse();
    check("b_wrap_239", 32'(b_row[0 +: 8]), 32'd239);
    b_hs_pulse();
    check("b_wrap_0", 32'(b_row[0 +: 8]), 32'd0);
    b_hs_pulse();
    check("b_wrap_1", 32'(b_row[0 +: 8]), 32'd1);

    // Out-of-range written value folds once; reload adds the offset mod height.
    b_write(2'd2, 1'b0, 15'd250);
    check("b_pend2", 32'(b_pend), 32'h4);
    b_vblank = 1'b1; tick(); tick();
    check("b_off_row0", 32'(b_row[0 +: 8]),  32'd8);
    check("b_off_row1", 32'(b_row[8 +: 8]),  32'd10);
    check("b_off_row2", 32'(b_row[16 +: 8]), 32'd20);
    check("b_off_pend", 32'(b_pend), 32'h0);
    b_vblank = 1'b0; tick();

    // Select beyond the layer count is ignored for writes and latches.
    b_write(2'd3, 1'b1, 15'h055);
    check("b_sel3_rows", 32'(b_row), 32'h140A08);
    check("b_sel3_pend", 32'(b_pend), 32'h0);
    b_sel = 2'd3; b_vrd = 16'hFFFF; b_hdl = 1'b1; tick();
    b_hdl = 1'b0; tick(); tick();
    check("b_sel3_pp",    32'(b_pp),    32'h0);
    check("b_sel3_hflip", 32'(b_hflip), 32'h0);

    // Latch on layer 2 only.
    b_sel = 2'd2; b_vrd = 16'h403F; b_hdl = 1'b1; tick();
    b_hdl = 1'b0; tick(); tick();
    check("b_attr_pp",    32'(b_pp),    32'(21'h7F << 14));
    check("b_attr_hflip", 32'(b_hflip), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
